// File: rtl/cordic_req_sched.sv
// Round-robin front end sharing one iterative CORDIC engine among NUM_REQ clients.
// One job in flight at a time; a timed-out job returns zeros with rsp_err set.
module cordic_req_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ANGLE_W = 24,
  parameter int unsigned RES_W   = 24,
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ANGLE_W-1:0]         eng_angle,
  output logic                       eng_valid,
  input  logic                       eng_done,
  input  logic [RES_W-1:0]           eng_cos,
  input  logic [RES_W-1:0]           eng_sin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [RES_W-1:0]           rsp_cos,
  output logic [RES_W-1:0]           rsp_sin,
  output logic                       rsp_err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               eng_valid_q, eng_valid_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]   rsp_cos_q, rsp_cos_d;
  logic [RES_W-1:0]   rsp_sin_q, rsp_sin_d;
  logic               rsp_err_q, rsp_err_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  int unsigned        idx;

  // Search starts just above the last served requester and wraps around.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_q) + off) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    angle_d     = angle_q;
    eng_valid_d = 1'b0;
    timer_d     = timer_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_cos_d   = rsp_cos_q;
    rsp_sin_d   = rsp_sin_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          gid_d       = grant_id;
          angle_d     = req_angle[int'(grant_id)*ANGLE_W +: ANGLE_W];
          eng_valid_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // A completion in the final allowed cycle still beats the timeout.
        if (eng_done) begin
          rsp_cos_d   = eng_cos;
          rsp_sin_d   = eng_sin;
          rsp_err_d   = 1'b0;
          rsp_id_d    = gid_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          rsp_cos_d   = '0;
          rsp_sin_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = gid_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          last_d      = rsp_id_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= ID_W'(NUM_REQ - 1);
      gid_q       <= '0;
      angle_q     <= '0;
      eng_valid_q <= 1'b0;
      timer_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_cos_q   <= '0;
      rsp_sin_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gid_q       <= gid_d;
      angle_q     <= angle_d;
      eng_valid_q <= eng_valid_d;
      timer_q     <= timer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cos_q   <= rsp_cos_d;
      rsp_sin_q   <= rsp_sin_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign eng_angle = angle_q;
  assign eng_valid = eng_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_cos   = rsp_cos_q;
  assign rsp_sin   = rsp_sin_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cordic_req_sched.sv
// Directed plus randomized bench for cordic_req_sched; the engine is played by the bench
// and expected grants/responses come from a small round-robin/timeout model.
module tb_cordic_req_sched;
  localparam int N  = 4;
  localparam int AW = 24;
  localparam int RW = 24;
  localparam int TO = 63;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_angle;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   eng_angle;
  logic            eng_valid;
  logic            eng_done;
  logic [RW-1:0]   eng_cos;
  logic [RW-1:0]   eng_sin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [RW-1:0]   rsp_cos;
  logic [RW-1:0]   rsp_sin;
  logic            rsp_err;

  int checks   = 0;
  int failures = 0;
  int last_m;

  always #5 clk = ~clk;

  cordic_req_sched #(
    .NUM_REQ (N),
    .ANGLE_W (AW),
    .RES_W   (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .eng_angle (eng_angle),
    .eng_valid (eng_valid),
    .eng_done  (eng_done),
    .eng_cos   (eng_cos),
    .eng_sin   (eng_sin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cos   (rsp_cos),
    .rsp_sin   (rsp_sin),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next requester strictly above 'last', else the lowest one at or below it.
  function automatic int rr_pick(input int last, input logic [N-1:0] m);
    for (int i = last + 1; i < N; i++) if (m[i]) return i;
    for (int i = 0; i <= last; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_eng_valid"}, eng_valid, 0);
    chk({tag, "_eng_angle"}, eng_angle, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_cos"}, rsp_cos, 0);
    chk({tag, "_rsp_sin"}, rsp_sin, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // k = cycles from eng_valid to eng_done (0 = engine never answers).
  task automatic run_job(input logic [N-1:0] mask, input logic [N*AW-1:0] angles, input int k,
                         input logic [RW-1:0] c, input logic [RW-1:0] s, input int hold,
                         input bit keep);
    int            g;
    int            rn;
    bit            err;
    logic [AW-1:0] a;
    logic [N-1:0]  oh;
    g   = rr_pick(last_m, mask);
    a   = angles[g*AW +: AW];
    oh  = '0;
    oh[g] = 1'b1;
    err = !(k >= 1 && k <= TO);
    rn  = err ? 2 + TO : 2 + k;
    req_valid = mask;
    req_angle = angles;
    #1;
    chk("req_ready_grant", req_ready, oh);
    cyc();
    chk("eng_valid_pulse", eng_valid, 1);
    chk("eng_angle", eng_angle, a);
    chk("req_ready_issue", req_ready, 0);
    if (!keep) req_valid = '0;
    cyc();
    for (int n = 2; n < rn; n++) begin
      chk("rsp_early", rsp_valid, 0);
      chk("eng_valid_extra", eng_valid, 0);
      if (n == k + 1) begin
        eng_done = 1'b1;
        eng_cos  = c;
        eng_sin  = s;
      end
      cyc();
      eng_done = 1'b0;
      eng_cos  = RW'($urandom);
      eng_sin  = RW'($urandom);
    end
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_cos", rsp_cos, err ? '0 : c);
      chk("rsp_sin", rsp_sin, err ? '0 : s);
      chk("rsp_err", rsp_err, err);
      chk("req_ready_resp", req_ready, 0);
      if (h == hold) rsp_ready = 1'b1;
      cyc();
    end
    rsp_ready = 1'b0;
    last_m = g;
    chk("rsp_dropped", rsp_valid, 0);
  endtask

  initial begin
    logic [N*AW-1:0] ang;
    logic [N-1:0]    m;
    rst       = 1'b1;
    req_valid = '1;
    req_angle = '0;
    eng_done  = 1'b0;
    eng_cos   = '0;
    eng_sin   = '0;
    rsp_ready = 1'b0;
    cyc();
    chk("req_ready_in_reset", req_ready, 0);
    cyc();
    chk("req_ready_in_reset2", req_ready, 0);
    chk_idle_outputs("reset");
    req_valid = '0;
    rst = 1'b0;
    last_m = N - 1;
    cyc();

    // pi/2 on requester 0
    ang = '0;
    ang[0 +: AW] = 24'h3243F6;
    run_job(4'b0001, ang, 24, 24'h000000, 24'h200000, 0, 1'b0);

    // All valid continuously: rotation
    ang = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++)
      run_job(4'b1111, ang, int'($urandom_range(1, 30)), RW'($urandom), RW'($urandom), 0, i < 4);

    // Timeout, then a late completion in IDLE
    run_job(4'(($urandom_range(1, 15))), {$urandom, $urandom, $urandom}, 0, 24'h123456,
            24'h654321, 0, 1'b0);
    eng_done = 1'b1;
    eng_cos  = 24'hABCDEF;
    eng_sin  = 24'h0FEDCB;
    cyc();
    eng_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_done_rsp", rsp_valid, 0);
      chk("late_done_issue", eng_valid, 0);
      cyc();
    end

    // Done in the very last allowed cycle wins over the timeout
    run_job(4'b0100, {$urandom, $urandom, $urandom}, TO, 24'h0A0B0C, 24'h0C0B0A, 0, 1'b0);

    // Backpressure for 10 cycles with other requesters pending
    run_job(4'b1111, {$urandom, $urandom, $urandom}, 5, RW'($urandom), RW'($urandom), 10, 1'b0);

    // Reset during WAIT with pi in flight on requester 2
    ang = {$urandom, $urandom, $urandom};
    ang[2*AW +: AW] = 24'h6487ED;
    req_valid = 4'b0100;
    req_angle = ang;
    #1;
    chk("rst_job_grant", req_ready, 4'b0100);
    cyc();
    chk("rst_job_angle", eng_angle, 24'h6487ED);
    req_valid = '0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_idle_outputs("midjob_reset");
    last_m = N - 1;
    eng_done = 1'b1;
    eng_cos  = 24'h111111;
    eng_sin  = 24'h222222;
    cyc();
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_rsp", rsp_valid, 0);
      cyc();
    end
    run_job(4'b1111, {$urandom, $urandom, $urandom}, 3, RW'($urandom), RW'($urandom), 0, 1'b0);

    // last_grant=1 with requesters 1 and 3 pending
    run_job(4'b0010, {$urandom, $urandom, $urandom}, 2, RW'($urandom), RW'($urandom), 0, 1'b0);
    run_job(4'b1010, {$urandom, $urandom, $urandom}, 4, RW'($urandom), RW'($urandom), 0, 1'b0);
    run_job(4'b1010, {$urandom, $urandom, $urandom}, 4, RW'($urandom), RW'($urandom), 0, 1'b0);

    // Random jobs
    for (int i = 0; i < 6; i++) begin
      m = 4'($urandom_range(1, 15));
      run_job(m, {$urandom, $urandom, $urandom}, int'($urandom_range(1, 40)), RW'($urandom),
              RW'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
